// File: rtl/mux_arb_pkg.sv
// Shared constants and index helpers for the round-robin arbiter/mux.
package mux_arb_pkg;

  localparam int DEF_N = 8;
  localparam int DEF_W = 8;

  // Wrap-around increment: n-1 rolls back to 0.
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotated priority search: first requester at or above ptr, wrapping.
module rr_pick #(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [SW-1:0] ptr_i,
  output logic          any_o,
  output logic [SW-1:0] win_o
);

  logic [SW:0] idx;

  // Scan from the farthest offset down so the closest requester to ptr wins last.
  always_comb begin
    any_o = 1'b0;
    win_o = '0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = {1'b0, ptr_i} + (SW + 1)'(k);
      if (idx >= (SW + 1)'(N)) idx = idx - (SW + 1)'(N);
      if (req_i[idx[SW-1:0]]) begin
        any_o = 1'b1;
        win_o = idx[SW-1:0];
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter feeding a registered N:1 mux with valid/ready backpressure.
module rr_mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int W  = DEF_W,
  parameter int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   ack,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_sel,
  input  logic           out_ready
);

  logic [SW-1:0] ptr_q, ptr_d;
  logic          valid_q, valid_d;
  logic [W-1:0]  data_q, data_d;
  logic [SW-1:0] sel_q, sel_d;

  logic          any;
  logic [SW-1:0] win;
  logic [W-1:0]  win_data;
  logic          load;

  rr_pick #(.N(N), .SW(SW)) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .any_o (any),
    .win_o (win)
  );

  assign load = !valid_q || out_ready;

  always_comb begin
    win_data = '0;
    for (int i = 0; i < N; i++) begin
      if (win == SW'(i)) win_data = in_data[i*W +: W];
    end
  end

  // rst_n gates ack so it drops the instant reset asserts, not at the next edge.
  assign ack = (rst_n && load && any) ? (N'(1) << win) : '0;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    if (load) begin
      if (any) begin
        valid_d = 1'b1;
        data_d  = win_data;
        sel_d   = win;
        ptr_d   = SW'(next_idx(32'(win), N));
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_sel   = sel_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: directed scenarios plus constrained-random traffic against a reference model.
module tb_rr_mux_arbiter;

  localparam int N  = 8;
  localparam int W  = 8;
  localparam int SW = $clog2(N);

  logic                   clk;
  logic                   rst_n;
  logic [N-1:0]           req;
  logic [N-1:0][W-1:0]    dat;
  logic [N*W-1:0]         in_data;
  logic [N-1:0]           ack;
  logic                   out_valid;
  logic [W-1:0]           out_data;
  logic [SW-1:0]          out_sel;
  logic                   out_ready;

  assign in_data = dat;

  rr_mux_arbiter #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .in_data   (in_data),
    .ack       (ack),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_valid;
  logic [W-1:0] m_data;
  int          m_sel;
  int          m_ptr;
  logic [N-1:0] ack_exp;
  logic [N-1:0] ack_seen;

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_sel   = 0;
    m_ptr   = 0;
  endtask

  // One clock: sample ack mid-cycle, then advance the model across the edge.
  task automatic tick();
    int w;
    bit ld;
    @(negedge clk);
    ld = !m_valid || out_ready;
    w  = -1;
    for (int k = 0; k < N; k++) begin
      if (w < 0 && ((req >> ((m_ptr + k) % N)) & N'(1)) != 0) w = (m_ptr + k) % N;
    end
    ack_exp = (ld && w >= 0) ? (N'(1) << w) : '0;
    ack_seen = ack;
    @(posedge clk);
    if (ld) begin
      if (w >= 0) begin
        m_valid = 1'b1;
        m_data  = W'(in_data >> (w * W));
        m_sel   = w;
        m_ptr   = (w + 1) % N;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req       = '0;
    out_ready = 1'b0;
    #2;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic load_ramp();
    for (int i = 0; i < N; i++) dat[i] = W'(i + 8'h10);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req       = '1;
    out_ready = 1'b1;
    load_ramp();
    model_reset();
    #2;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_sel !== '0 || ack !== '0) begin
      errors++;
      $display("FAIL reset_state got v=%b d=%h s=%0d ack=%b want v=0 d=00 s=0 ack=0",
               out_valid, out_data, out_sel, ack);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_sel !== SW'(0) || ack_seen !== N'(1)) begin
      errors++;
      $display("FAIL reset_first_grant got v=%b s=%0d ack=%b want v=1 s=0 ack=00000001",
               out_valid, out_sel, ack_seen);
    end
  endtask

  task automatic test_single();
    do_reset();
    dat       = '0;
    dat[2]    = 8'hA5;
    req       = 8'b0000_0100;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (ack_seen !== 8'b0000_0100 || out_valid !== 1'b1 || out_sel !== SW'(2) || out_data !== 8'hA5) begin
        errors++;
        $display("FAIL single_req c=%0d got ack=%b v=%b s=%0d d=%h want ack=00000100 v=1 s=2 d=a5",
                 c, ack_seen, out_valid, out_sel, out_data);
      end
    end
  endtask

  task automatic test_all_rotate();
    do_reset();
    load_ramp();
    req       = '1;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_sel !== SW'(c % N) || out_data !== W'(8'h10 + c % N)
          || ack_seen !== (N'(1) << (c % N))) begin
        errors++;
        $display("FAIL all_rotate c=%0d got s=%0d d=%h ack=%b want s=%0d d=%h",
                 c, out_sel, out_data, ack_seen, c % N, 8'h10 + c % N);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    load_ramp();
    req       = '1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (ack_seen !== '0 || out_valid !== 1'b1 || out_sel !== SW'(0) || out_data !== 8'h10) begin
        errors++;
        $display("FAIL stall c=%0d got ack=%b v=%b s=%0d d=%h want ack=0 v=1 s=0 d=10",
                 c, ack_seen, out_valid, out_sel, out_data);
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (ack_seen !== 8'b0000_0010 || out_sel !== SW'(1) || out_data !== 8'h11) begin
      errors++;
      $display("FAIL stall_release got ack=%b s=%0d d=%h want ack=00000010 s=1 d=11",
               ack_seen, out_sel, out_data);
    end
  endtask

  task automatic test_wrap_skip();
    do_reset();
    load_ramp();
    out_ready = 1'b1;
    req = 8'b0100_0000;
    tick();
    checks++;
    if (out_sel !== SW'(6) || out_data !== 8'h16) begin
      errors++;
      $display("FAIL wrap_grant6 got s=%0d d=%h want s=6 d=16", out_sel, out_data);
    end
    req = 8'b1000_0010;
    tick();
    checks++;
    if (out_sel !== SW'(7) || out_data !== 8'h17 || ack_seen !== 8'b1000_0000) begin
      errors++;
      $display("FAIL wrap_grant7 got s=%0d d=%h ack=%b want s=7 d=17", out_sel, out_data, ack_seen);
    end
    tick();
    checks++;
    if (out_sel !== SW'(1) || out_data !== 8'h11 || ack_seen !== 8'b0000_0010) begin
      errors++;
      $display("FAIL wrap_grant1 got s=%0d d=%h ack=%b want s=1 d=11", out_sel, out_data, ack_seen);
    end
  endtask

  task automatic test_idle_drain();
    do_reset();
    load_ramp();
    out_ready = 1'b1;
    req = 8'b0000_1000;
    tick();
    req = '0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_sel !== SW'(3) || out_data !== 8'h13 || ack_seen !== '0) begin
      errors++;
      $display("FAIL idle_drain got v=%b s=%0d d=%h ack=%b want v=0 s=3 d=13 ack=0",
               out_valid, out_sel, out_data, ack_seen);
    end
    out_ready = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_sel !== SW'(3)) begin
      errors++;
      $display("FAIL idle_hold got v=%b s=%0d want v=0 s=3", out_valid, out_sel);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    load_ramp();
    req       = '1;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || ack !== '0) begin
      errors++;
      $display("FAIL reset_mid_async got v=%b ack=%b want v=0 ack=0", out_valid, ack);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_sel !== SW'(0) || out_data !== 8'h10) begin
      errors++;
      $display("FAIL reset_mid_restart got v=%b s=%0d d=%h want v=1 s=0 d=10",
               out_valid, out_sel, out_data);
    end
  endtask

  task automatic test_random();
    int bad;
    do_reset();
    bad = 0;
    for (int i = 0; i < N; i++) dat[i] = W'($urandom);
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        // A raised request stays put until acknowledged; otherwise re-roll it.
        if (!(req[i] && !ack_seen[i]) || c == 0) begin
          req[i] = ($urandom_range(0, 2) == 0);
          dat[i] = W'($urandom);
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      checks++;
      if (ack_seen !== ack_exp || out_valid !== m_valid || out_sel !== SW'(m_sel) || out_data !== m_data) begin
        errors++;
        if (bad < 10)
          $display("FAIL random c=%0d got ack=%b v=%b s=%0d d=%h want ack=%b v=%b s=%0d d=%h",
                   c, ack_seen, out_valid, out_sel, out_data, ack_exp, m_valid, m_sel, m_data);
        bad++;
      end
    end
  endtask

  initial begin
    ack_seen = '0;
    ack_exp  = '0;
    test_reset();
    test_single();
    test_all_rotate();
    test_backpressure();
    test_wrap_skip();
    test_idle_drain();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Round-robin arbiter and registered N:1 data mux that shares one output channel among N requesters. Each requester presents a valid/data pair and receives a one-cycle acknowledge when its data is captured. The block picks the winner each cycle, drives the mux select, and holds the selected word in a single output register with valid/ready backpressure. It sits in front of any shared sink that previously took a static select from the plain N:1 mux.

## Interface
- N, default 8: number of requesters; must be at least 2.
- W, default 8: data width per requester.
- SW, default $clog2(N): select/pointer width; derived, never overridden.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N  per-requester valid; bit i qualifies slice i of in_data.
- in_data  input  N*W  flattened data; requester i occupies bits [i*W +: W].
- ack  output  N  one-hot (or zero) capture strobe; combinational.
- out_valid  output  1  output register holds a word.
- out_data  output  W  captured word.
- out_sel  output  SW  index of the requester whose word is in out_data.
- out_ready  input  1  sink accepts the word when out_valid is high.

## Operation
- load = !out_valid || out_ready: the output register is empty or is being drained this cycle.
- Winner: the first index with req set, searching from ptr upward and wrapping from N-1 to 0.
- Capture (at a clock edge where load is high and req is nonzero):
  - out_data <= in_data slice of the winner; out_sel <= winner; out_valid <= 1.
  - ptr <= winner+1, with N-1 wrapping to 0.
- ack[winner] = load && req[winner]. All other ack bits are 0. A transfer on requester i occurs when req[i] && ack[i].
- Load high with req == 0: out_valid <= 0. ptr, out_data and out_sel hold.
- Load low (out_valid && !out_ready): all registers and ptr hold. ack is 0. Requesters keep req and in_data stable.
- Requester rules:
  - Once req[i] is raised, it is held with in_data stable until ack[i].
  - A requester may keep req high to send back-to-back words.
- State machine (implicit in out_valid):
  - EMPTY → FULL on capture.
  - FULL → FULL on drain plus new capture.
  - FULL → EMPTY on drain with no req.
  - FULL → FULL on stall.
- Fairness: with all N requesting continuously and out_ready high, grants rotate strictly 0,1,…,N-1,0. No requester waits more than N-1 accepted transfers.
- Reset values: out_valid=0, out_data=0, out_sel=0, ptr=0, ack=0.

## Timing
- Latency: the word captured at edge t is visible on out_data/out_sel with out_valid high from t until the edge at which out_ready is sampled high.
- Throughput: one word per cycle when out_ready stays high.
- ack is combinational from req, out_valid, out_ready and ptr. It is asserted during the cycle before the capturing edge.
- Simultaneous drain and capture in one cycle is required. There is no bubble between consecutive words.
- Single requester holding req: it is captured every cycle. The pointer wrap does not block it.
- Reset mid-operation: asserting rst_n low clears out_valid and ack immediately (asynchronously). Any in-flight word is dropped. The next winner after release is searched from index 0.
- out_ready while out_valid is 0 has no effect.

## Structure
- Package mux_arb_pkg:
  - default N/W constants;
  - function next_idx(idx, n) implementing wrap-around increment.
- Sub-module rr_pick #(N, SW): purely combinational. Inputs req and ptr; outputs any and a binary winner index, via a rotated priority search. The top level holds ptr, the output register and the ack decode.

## Test plan
- Single requester: req=8'b0000_0100, in_data slice 2 = 8'hA5, out_ready=1. Required: ack[2] high each cycle; out_sel=2, out_data=8'hA5 and out_valid=1 from the next cycle.
- All requesting: req=8'hFF, slice i = i+8'h10, out_ready=1. Required: out_sel sequence 0,1,…,7,0,1 on consecutive cycles; out_data tracks 8'h10…8'h17.
- Backpressure: all requesting, out_ready=0 for 3 cycles after the first capture. Required: out_sel=0 and out_data=8'h10 held; ack=0 throughout. On out_ready=1, the next capture is index 1.
- Wrap and skip: after a grant to 6, req=8'b1000_0010. Required: next winner 7, then 1; ptr wraps past 0.
- Idle drain: one word captured, then req=0, out_ready=1. Required: out_valid drops the next cycle; out_sel/out_data hold their last values.
- Reset mid-stream: all requesting, with rst_n pulsed low between edges 3 and 4. Required: out_valid=0 and ack=0 immediately. After release, the first out_sel is 0.
